// File: rtl/mul_div_seq.sv
// rtl/mul_div_seq.sv - sequential unsigned shift-add multiplier / restoring divider, one step per clock
// Macro DIV_EN builds the divider; without it any op=1 request finishes at once with result=0, err=1.
module mul_div_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               err
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_n;
    logic [2*WIDTH-1:0] mcand_n;
    // Holds the multiplier in MUL, the developing quotient in DIV.
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shreg_n;
    logic               early_fin;

`ifdef DIV_EN
    logic               op_r;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   rem_n;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               ge;

    assign early_fin = start && op && (b == '0);
`else
    assign early_fin = start && op;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        acc_n   = shreg[0] ? (acc + mcand) : acc;
        mcand_n = mcand << 1;
`ifdef DIV_EN
        rem_sh  = {rem, shreg[WIDTH-1]};
        diff    = rem_sh - {1'b0, dvs};
        // rem < dvs holds before each step, so a set rem_sh MSB always means rem_sh >= dvs.
        ge      = rem_sh[WIDTH] | ~diff[WIDTH];
        rem_n   = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        shreg_n = op_r ? {shreg[WIDTH-2:0], ge} : (shreg >> 1);
`else
        shreg_n = shreg >> 1;
`endif
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = early_fin ? FIN : RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    next_state = FIN;
                end
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            shreg  <= '0;
            done   <= 1'b0;
            result <= '0;
            err    <= 1'b0;
`ifdef DIV_EN
            op_r   <= 1'b0;
            dvs    <= '0;
            rem    <= '0;
`endif
        end else begin
            done <= (next_state == FIN);

            if (state == IDLE && start) begin
                cnt   <= CW'(WIDTH);
                acc   <= '0;
                mcand <= {{WIDTH{1'b0}}, a};
                shreg <= op ? a : b;
`ifdef DIV_EN
                op_r  <= op;
                dvs   <= b;
                rem   <= '0;
`endif
            end else if (state == RUN) begin
                cnt   <= cnt - CW'(1);
                acc   <= acc_n;
                mcand <= mcand_n;
                shreg <= shreg_n;
`ifdef DIV_EN
                rem   <= rem_n;
`endif
            end

            // Result is captured on the edge into FIN so it is valid alongside done.
            if (next_state == FIN) begin
                if (state == IDLE) begin
                    err <= 1'b1;
`ifdef DIV_EN
                    result <= {a, {WIDTH{1'b1}}};
`else
                    result <= '0;
`endif
                end else begin
                    err <= 1'b0;
`ifdef DIV_EN
                    result <= op_r ? {rem_n, shreg_n} : acc_n;
`else
                    result <= acc_n;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_div_seq.sv
// tb/tb_mul_div_seq.sv - scoreboard testbench for mul_div_seq at WIDTH=8
// Expected DIV results follow the DIV_EN macro of the build.
module tb_mul_div_seq;
    localparam int W = 8;

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           op    = 1'b0;
    logic [W-1:0]   a     = '0;
    logic [W-1:0]   b     = '0;
    logic           busy;
    logic           done;
    logic           err;
    logic [2*W-1:0] result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int bcnt   = 0;
    logic [2*W-1:0] last_res = '0;
    logic           last_err = 1'b0;

    typedef struct {
        logic [2*W-1:0] res;
        logic           err;
        int             lat;
        int             acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    mul_div_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic o, input logic [7:0] x, input logic [7:0] y, input int ac);
        exp_t e;
        e.acc_cyc = ac;
        if (!o) begin
            e.res = {8'd0, x} * {8'd0, y};
            e.err = 1'b0;
            e.lat = W + 1;
        end else begin
`ifdef DIV_EN
            if (y == 8'd0) begin
                e.res = {x, 8'hFF};
                e.err = 1'b1;
                e.lat = 1;
            end else begin
                e.res = {x % y, x / y};
                e.err = 1'b0;
                e.lat = W + 1;
            end
`else
            e.res = '0;
            e.err = 1'b1;
            e.lat = 1;
`endif
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            bcnt = 0;
        end else begin
            if (busy) bcnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("result", result, mon_e.res);
                    check("err", err, mon_e.err);
                    check("latency", cyc - mon_e.acc_cyc + 1, mon_e.lat);
                    check("busy_cycles", bcnt, mon_e.lat);
                    last_res = mon_e.res;
                    last_err = mon_e.err;
                end
                bcnt = 0;
            end
        end
    end

    task automatic issue(input logic o, input logic [7:0] x, input logic [7:0] y);
        int t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("idle_wait", t, 0);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        sb.push_back(model(o, x, y, cyc + 1));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        logic       ro;
        logic [7:0] rx;
        logic [7:0] ry;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        @(negedge clk);

        issue(1'b0, 8'd13, 8'd11);
        issue(1'b0, 8'hFF, 8'hFF);
        issue(1'b1, 8'd100, 8'd7);
        issue(1'b1, 8'd7, 8'd100);
        drain();
        repeat (3) @(negedge clk);
        check("hold_result", result, last_res);
        check("hold_err", err, last_err);

        issue(1'b1, 8'd5, 8'd0);
        issue(1'b0, 8'd2, 8'd3);

        // A start pulse while busy must not disturb the running 3*4.
        issue(1'b0, 8'd3, 8'd4);
        @(negedge clk);
        op = 1'b0;
        a = 8'd9;
        b = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset in the middle of a multiply aborts it without a done pulse.
        issue(1'b0, 8'd3, 8'd4);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_err", err, 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        bcnt = 0;
        issue(1'b0, 8'd6, 8'd7);

        issue(1'b0, 8'd0, 8'd200);
        issue(1'b0, 8'd1, 8'd255);
        issue(1'b1, 8'd0, 8'd9);
        issue(1'b1, 8'd255, 8'd1);
        issue(1'b1, 8'd200, 8'd201);

        for (int i = 0; i < 16; i++) begin
            ro = 1'($urandom_range(0, 1));
            rx = 8'($urandom);
            ry = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            issue(ro, rx, ry);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

endmodule
